// File: rtl/alu_pkg.sv
// Shared ALU issue types: ALUOp codes, RV32 opcode and funct7 constants, base funct3 map.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101,
    ALU_MUL  = 4'b1110
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 -> op with funct7 at its base value; SUB/SRA/MUL are patched in by the decoder.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of RV32 instruction fields into ALU operands and ALUOp.
// Build macro ALU_ISSUE_MUL_EN enables the OP funct7=0000001 funct3=000 MUL encoding.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [3:0]      aluop,
  output logic            illegal
);

  alu_op_e op;

  always_comb begin
    op      = ALU_ADD;
    a       = '0;
    b       = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        a  = rs1;
        b  = rs2;
        op = f3_to_op(funct3);
        if (funct7 == F7_ALT && funct3 == 3'b000) op = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) op = ALU_SRA;
`ifdef ALU_ISSUE_MUL_EN
        else if (funct7 == F7_MULDIV && funct3 == 3'b000) op = ALU_MUL;
`else
`endif
        else if (funct7 != F7_BASE) illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        // funct7 only carries meaning for the shifts; elsewhere it is immediate bits.
        a  = rs1;
        b  = imm;
        op = f3_to_op(funct3);
        if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
        else if (funct3 == 3'b101 && funct7 == F7_ALT) op = ALU_SRA;
        else if (funct3 == 3'b101 && funct7 != F7_BASE) illegal = 1'b1;
      end
      OPC_LUI: begin
        b = imm;
      end
      OPC_AUIPC: begin
        a = pc;
        b = imm;
      end
      OPC_LOAD, OPC_STORE: begin
        a = rs1;
        b = imm;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      op = ALU_ADD;
      a  = '0;
      b  = '0;
    end
  end

  assign aluop = op;

endmodule

// File: rtl/alu_op_issuer.sv
// ALU operand/opcode issuer: decode, 2-entry skid buffer and saturating illegal counter.
// Build macro ALU_ISSUE_MUL_EN (see alu_op_decode) adds the MUL encoding.
//
// Handshake: a beat moves on a side when valid && ready are both high at the rising edge;
// out_* are registered and held while out_valid && !out_ready; in_ready depends only on
// the registered buffer state (never on out_ready) and producers must not rely on it combinationally.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [3:0]       out_aluop,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  head_a_q, head_b_q, tail_a_q, tail_b_q;
  logic [3:0]       head_op_q, tail_op_q;
  logic             head_ill_q, tail_ill_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  dec_a, dec_b;
  logic [3:0]       dec_op;
  logic             dec_ill;
  logic             push, pop, load_head, load_tail, shift_tail;

  alu_op_decode #(.XLEN(XLEN)) u_decode (
    .opcode  (in_opcode),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .pc      (in_pc),
    .a       (dec_a),
    .b       (dec_b),
    .aluop   (dec_op),
    .illegal (dec_ill)
  );

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    shift_tail = 1'b0;
    case (state_q)
      ST_EMPTY: if (push) begin
        load_head = 1'b1;
        state_d   = ST_ONE;
      end
      ST_ONE: begin
        if (push && pop) load_head = 1'b1;
        else if (push) begin
          load_tail = 1'b1;
          state_d   = ST_FULL;
        end else if (pop) state_d = ST_EMPTY;
      end
      ST_FULL: if (pop) begin
        shift_tail = 1'b1;
        state_d    = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // The counter sees every accepted illegal entry, even one a same-cycle flush discards.
  always_comb begin
    cnt_d = cnt_q;
    if (push && dec_ill && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      head_a_q   <= '0;
      head_b_q   <= '0;
      head_op_q  <= '0;
      head_ill_q <= 1'b0;
      tail_a_q   <= '0;
      tail_b_q   <= '0;
      tail_op_q  <= '0;
      tail_ill_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_head) begin
        head_a_q   <= dec_a;
        head_b_q   <= dec_b;
        head_op_q  <= dec_op;
        head_ill_q <= dec_ill;
      end else if (shift_tail) begin
        head_a_q   <= tail_a_q;
        head_b_q   <= tail_b_q;
        head_op_q  <= tail_op_q;
        head_ill_q <= tail_ill_q;
      end
      if (load_tail) begin
        tail_a_q   <= dec_a;
        tail_b_q   <= dec_b;
        tail_op_q  <= dec_op;
        tail_ill_q <= dec_ill;
      end
    end
  end

  assign out_a       = head_a_q;
  assign out_b       = head_b_q;
  assign out_aluop   = head_op_q;
  assign out_illegal = head_ill_q;
  assign illegal_cnt = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer (small counter width so saturation is reachable).
module tb_alu_op_issuer;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [6:0]       in_opcode, in_funct7;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_rs1, in_rs2, in_imm, in_pc, out_a, out_b;
  logic [3:0]       out_aluop;
  logic [CNT_W-1:0] illegal_cnt;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  alu_op_issuer #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct3   (in_funct3),
    .in_funct7   (in_funct7),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_aluop   (out_aluop),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1, rs2, imm, pc;
    logic [31:0] ea, eb;
    logic [3:0]  eop;
    logic        eill;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc);
    in_valid  = v;
    in_opcode = opc;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_pc     = pc;
  endtask

  task automatic idle();
    drive(1'b0, 7'h0, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    vecs[0] = '{7'b0110011, 3'b000, 7'h20, 32'd10, 32'd3, 32'd0, 32'd0, 32'd10, 32'd3, 4'b1000, 1'b0};
    vecs[1] = '{7'b0110011, 3'b011, 7'h00, 32'd4, 32'd6, 32'd0, 32'd0, 32'd4, 32'd6, 4'b0011, 1'b0};
    vecs[2] = '{7'b0110011, 3'b001, 7'h20, 32'd4, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0000, 1'b1};
    vecs[3] = '{7'b0010011, 3'b010, 7'h7f, 32'd1, 32'd9, 32'hffffffff, 32'd0, 32'd1, 32'hffffffff, 4'b0010, 1'b0};
    vecs[4] = '{7'b0010011, 3'b000, 7'h20, 32'd7, 32'd9, 32'h00000400, 32'd0, 32'd7, 32'h00000400, 4'b0000, 1'b0};
    vecs[5] = '{7'b0010011, 3'b001, 7'h20, 32'd7, 32'd9, 32'd3, 32'd0, 32'd0, 32'd0, 4'b0000, 1'b1};
    vecs[6] = '{7'b0110111, 3'b000, 7'h00, 32'd99, 32'd9, 32'h12345000, 32'h40, 32'd0, 32'h12345000, 4'b0000, 1'b0};
    vecs[7] = '{7'b0010111, 3'b000, 7'h00, 32'd99, 32'd9, 32'h2000, 32'h1000, 32'h1000, 32'h2000, 4'b0000, 1'b0};
    vecs[8] = '{7'b0100011, 3'b010, 7'h00, 32'h100, 32'd9, 32'd8, 32'h0, 32'h100, 32'd8, 4'b0000, 1'b0};
    vecs[9] = '{7'b0000011, 3'b010, 7'h00, 32'h200, 32'd9, 32'hfffffffc, 32'h0, 32'h200, 32'hfffffffc, 4'b0000, 1'b0};

    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    idle();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_aluop", out_aluop, 0);
    check("rst_illegal_cnt", illegal_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("in_ready_after_reset", in_ready, 1);

    // 1: basic ADD, single-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 7'b0110011, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0);
    step();
    check("t1_valid", out_valid, 1);
    check("t1_a", out_a, 5);
    check("t1_b", out_b, 7);
    check("t1_aluop", out_aluop, 4'b0000);
    idle();
    step();
    check("t1_drained", out_valid, 0);

    // 2: OP-IMM SRA then SRL back to back
    drive(1'b1, 7'b0010011, 3'b101, 7'h20, 32'h80000000, 32'd0, 32'd4, 32'd0);
    step();
    check("t2_sra_op", out_aluop, 4'b1101);
    check("t2_sra_a", out_a, 32'h80000000);
    check("t2_sra_b", out_b, 4);
    in_funct7 = 7'h00;
    step();
    check("t2_srl_op", out_aluop, 4'b0101);
    check("t2_srl_valid", out_valid, 1);
    idle();
    step();

    // 3: backpressure fills the buffer, then drains in order
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b100, 7'h00, 32'd1, 32'd2, 32'd0, 32'd0);
    step();
    check("t3_e1_op", out_aluop, 4'b0100);
    check("t3_ready_one", in_ready, 1);
    drive(1'b1, 7'b0110011, 3'b110, 7'h00, 32'd3, 32'd4, 32'd0, 32'd0);
    step();
    check("t3_ready_full", in_ready, 0);
    check("t3_hold_op", out_aluop, 4'b0100);
    drive(1'b1, 7'b0110011, 3'b111, 7'h00, 32'd5, 32'd6, 32'd0, 32'd0);
    step();
    check("t3_still_full", in_ready, 0);
    check("t3_hold_a", out_a, 1);
    check("t3_hold_b", out_b, 2);
    idle();
    out_ready = 1'b1;
    step();
    check("t3_pop2_op", out_aluop, 4'b0110);
    check("t3_pop2_a", out_a, 3);
    check("t3_pop2_valid", out_valid, 1);
    check("t3_pop2_ready", in_ready, 1);
    step();
    check("t3_empty", out_valid, 0);

    // 4: illegal opcode and counter saturation (max 15)
    drive(1'b1, 7'b1110011, 3'b000, 7'h00, 32'd9, 32'd9, 32'd9, 32'd9);
    step();
    check("t4_illegal", out_illegal, 1);
    check("t4_aluop", out_aluop, 0);
    check("t4_a", out_a, 0);
    check("t4_b", out_b, 0);
    check("t4_cnt1", illegal_cnt, 1);
    repeat (13) step();
    check("t4_cnt14", illegal_cnt, 14);
    step();
    check("t4_cnt15", illegal_cnt, 15);
    repeat (3) step();
    check("t4_cnt_sat", illegal_cnt, 15);
    idle();
    step();

    // 5: MUL encoding
    drive(1'b1, 7'b0110011, 3'b000, 7'h01, 32'd6, 32'd7, 32'd0, 32'd0);
    step();
`ifdef ALU_ISSUE_MUL_EN
    check("t5_mul_op", out_aluop, 4'b1110);
    check("t5_mul_ill", out_illegal, 0);
    check("t5_mul_a", out_a, 6);
`else
    check("t5_mul_op", out_aluop, 4'b0000);
    check("t5_mul_ill", out_illegal, 1);
    check("t5_mul_a", out_a, 0);
`endif
    idle();
    step();

    // directed decode table
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pc);
      step();
      check($sformatf("vec%0d_op", i), out_aluop, vecs[i].eop);
      check($sformatf("vec%0d_a", i), out_a, vecs[i].ea);
      check($sformatf("vec%0d_b", i), out_b, vecs[i].eb);
      check($sformatf("vec%0d_ill", i), out_illegal, vecs[i].eill);
    end
    idle();
    step();

    // 6: asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 7'h00, 32'd11, 32'd12, 32'd0, 32'd0);
    step();
    step();
    check("t6_full_before_rst", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_a", out_a, 0);
    check("t6_rst_b", out_b, 0);
    check("t6_rst_cnt", illegal_cnt, 0);
    check("t6_rst_ready", in_ready, 1);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 6: flush on a FULL buffer with in_valid held
    drive(1'b1, 7'b0110011, 3'b000, 7'h00, 32'd1, 32'd1, 32'd0, 32'd0);
    step();
    step();
    check("t6_full", in_ready, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_flush_valid", out_valid, 0);
    check("t6_flush_ready", in_ready, 1);

    // flush still counts an illegal entry accepted in the same cycle
    drive(1'b1, 7'b1111111, 3'b000, 7'h00, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    check("t6_cnt1", illegal_cnt, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    check("t6_flush_cnt", illegal_cnt, 2);
    check("t6_flush_valid2", out_valid, 0);
    step();
    check("t6_idle_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
